// File: rtl/clock_period_meter.sv
// Measures the period and high time of a slow clock-like input in clk_in cycles.
// Also flags lock after repeated equal periods, and a stall when no edge arrives in time.
module clock_period_meter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           sig_in,
  output logic [WIDTH:0] period_out,
  output logic [WIDTH:0] high_out,
  output logic           meas_valid,
  output logic           locked,
  output logic           stalled
);

  localparam int            CW     = WIDTH + 1;
  localparam logic [CW-1:0] MAX    = '1;
  localparam int            MW     = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s, sig_d, rise, fall;
  logic [CW-1:0]          per_cnt, per_cnt_n;
  logic [CW-1:0]          hi_cap, hi_cap_n;
  logic [CW-1:0]          prev_per, prev_per_n;
  logic [MW-1:0]          match_cnt, match_n;
  logic [CW-1:0]          period_n, high_n;
  logic                   valid_n, locked_n, stalled_n;
  logic                   measure, timeout;
  logic [CW-1:0]          per_inc;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sig_s;
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign fall  = ~sig_s & sig_d;

  // Saturating increment: the counter must never wrap back to a small period.
  assign per_inc = (per_cnt == MAX) ? MAX : per_cnt + 1'b1;

  always_comb begin
    state_n    = state;
    per_cnt_n  = per_cnt;
    hi_cap_n   = hi_cap;
    prev_per_n = prev_per;
    match_n    = match_cnt;
    period_n   = period_out;
    high_n     = high_out;
    valid_n    = 1'b0;
    locked_n   = locked;
    stalled_n  = stalled;
    measure    = 1'b0;
    timeout    = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          state_n   = HIGH;
          per_cnt_n = CW'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          state_n   = LOW;
          hi_cap_n  = per_cnt;
          per_cnt_n = per_inc;
        end else if (per_cnt == MAX) begin
          timeout = 1'b1;
        end else begin
          per_cnt_n = per_inc;
        end
      end
      LOW: begin
        // A rise on the last count still closes the period (reports MAX).
        if (rise) begin
          measure   = 1'b1;
          state_n   = HIGH;
          per_cnt_n = CW'(1);
        end else if (per_cnt == MAX) begin
          timeout = 1'b1;
        end else begin
          per_cnt_n = per_inc;
        end
      end
      default: state_n = IDLE;
    endcase

    if (timeout) begin
      state_n   = IDLE;
      per_cnt_n = '0;
      stalled_n = 1'b1;
      locked_n  = 1'b0;
      match_n   = '0;
    end

    if (measure) begin
      period_n   = per_cnt;
      high_n     = hi_cap;
      valid_n    = 1'b1;
      stalled_n  = 1'b0;
      prev_per_n = per_cnt;
      if (match_cnt == '0 || per_cnt != prev_per) begin
        match_n  = MW'(1);
        locked_n = 1'b0;
      end else begin
        match_n  = (match_cnt >= LOCK_N) ? LOCK_N : match_cnt + 1'b1;
        locked_n = (match_n == LOCK_N);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cap     <= '0;
      prev_per   <= '0;
      match_cnt  <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      state      <= state_n;
      per_cnt    <= per_cnt_n;
      hi_cap     <= hi_cap_n;
      prev_per   <= prev_per_n;
      match_cnt  <= match_n;
      period_out <= period_n;
      high_out   <= high_n;
      meas_valid <= valid_n;
      locked     <= locked_n;
      stalled    <= stalled_n;
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: table of steady waveforms plus hand-written
// sequences for ratio switch, stall, and reset mid-measurement.
module tb_clock_period_meter;

  localparam int WIDTH      = 8;
  localparam int CW         = WIDTH + 1;
  localparam int LOCK_COUNT = 4;
  localparam int EW         = 32 + CW + CW + 1;

  logic          clk_in = 1'b0;
  logic          rst    = 1'b1;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period_out;
  logic [CW-1:0] high_out;
  logic          meas_valid;
  logic          locked;
  logic          stalled;

  clock_period_meter #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2),
    .LOCK_COUNT (LOCK_COUNT)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sig_in    (sig_in),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .locked    (locked),
    .stalled   (stalled)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Each entry: {expected cycle of meas_valid, period, high, locked}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  typedef struct {
    int h;
    int l;
    int per;
    int hi;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic push_exp(input int per, input int hi, input bit lk);
    logic [31:0]   c;
    logic [CW-1:0] p;
    logic [CW-1:0] hv;
    c  = 32'(cyc + 3);
    p  = per[CW-1:0];
    hv = hi[CW-1:0];
    exp_q.push_back({c, p, hv, lk});
  endtask

  // Rising edge now (optionally closing a period), high for h cycles, low for l.
  task automatic drive_period(input int h, input int l, input bit push,
                              input int per, input int hi, input bit lk);
    sig_in = 1'b1;
    if (push) push_exp(per, hi, lk);
    wait_cyc(h);
    sig_in = 1'b0;
    wait_cyc(l);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, int'(period_out), 0);
    check({tag, "_high"},   int'(high_out),   0);
    check({tag, "_valid"},  int'(meas_valid), 0);
    check({tag, "_locked"}, int'(locked),     0);
    check({tag, "_stalled"}, int'(stalled),   0);
  endtask

  task automatic do_reset(input string tag);
    check({tag, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
    sig_in = 1'b0;
    rst    = 1'b1;
    wait_cyc(3);
    check_zero({tag, "_rst"});
    rst = 1'b0;
    wait_cyc(4);
  endtask

  always @(negedge clk_in) begin
    if (!rst && meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid actual meas_valid=1 period %0d expected no pending report (cycle %0d)",
                 period_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", cyc,               int'(mon_e[EW-1:2*CW+1]));
        check("period",  int'(period_out),  int'(mon_e[2*CW:CW+1]));
        check("high",    int'(high_out),    int'(mon_e[CW:1]));
        check("locked",  int'(locked),      int'(mon_e[0]));
        check("stalled_clear", int'(stalled), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5, 5, 10, 5};
    vecs[1] = '{3, 7, 10, 3};
    vecs[2] = '{1, 1, 2, 1};
    vecs[3] = '{2, 2, 4, 2};
    for (int i = 4; i < 6; i++) begin
      vecs[i].h   = int'($urandom_range(1, 20));
      vecs[i].l   = int'($urandom_range(1, 20));
      vecs[i].per = vecs[i].h + vecs[i].l;
      vecs[i].hi  = vecs[i].h;
    end

    // Steady waveforms: first rise opens, each later rise closes a period.
    for (int i = 0; i < 6; i++) begin
      do_reset("table");
      for (int k = 0; k < 6; k++)
        drive_period(vecs[i].h, vecs[i].l, k > 0, vecs[i].per, vecs[i].hi, k >= LOCK_COUNT);
      wait_cyc(8);
    end

    // Ratio switch 4 -> 6 through a mixed period of 5.
    do_reset("switch");
    for (int k = 0; k < 6; k++)
      drive_period(2, 2, k > 0, 4, 2, k >= LOCK_COUNT);
    drive_period(2, 3, 1'b1, 4, 2, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) drive_period(3, 3, 1'b1, 5, 2, 1'b0);
      else        drive_period(3, 3, 1'b1, 6, 3, k >= LOCK_COUNT);
    end
    wait_cyc(8);

    // Stall: hold high well past the counter range, then resume at div 8.
    do_reset("stall");
    for (int k = 0; k < 6; k++)
      drive_period(4, 4, k > 0, 8, 4, k >= LOCK_COUNT);
    sig_in = 1'b1;
    push_exp(8, 4, 1'b1);
    wait_cyc(510);
    check("stall_early", int'(stalled), 0);
    wait_cyc(10);
    check("stall_set",    int'(stalled),    1);
    check("stall_locked", int'(locked),     0);
    check("stall_period", int'(period_out), 8);
    check("stall_high",   int'(high_out),   4);
    wait_cyc(80);
    sig_in = 1'b0;
    wait_cyc(4);
    check("stall_hold", int'(stalled), 1);
    drive_period(4, 4, 1'b0, 0, 0, 1'b0);
    check("stall_sticky", int'(stalled), 1);
    drive_period(4, 4, 1'b1, 8, 4, 1'b0);
    drive_period(4, 4, 1'b1, 8, 4, 1'b0);
    check("stall_cleared", int'(stalled), 0);
    wait_cyc(8);

    // Reset while in HIGH with div 12; first report afterwards must be a full 12.
    do_reset("rstmid");
    for (int k = 0; k < 3; k++)
      drive_period(6, 6, k > 0, 12, 6, 1'b0);
    sig_in = 1'b1;
    push_exp(12, 6, 1'b0);
    wait_cyc(5);
    rst = 1'b1;
    wait_cyc(2);
    sig_in = 1'b0;
    wait_cyc(2);
    check_zero("rstmid_during");
    rst = 1'b0;
    wait_cyc(3);
    drive_period(6, 6, 1'b0, 0, 0, 1'b0);
    drive_period(6, 6, 1'b1, 12, 6, 1'b0);
    drive_period(6, 6, 1'b1, 12, 6, 1'b0);
    wait_cyc(8);
    check("final_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Measuring counterpart of the clock divider. Samples a slow clock-like signal `sig_in` in the `clk_in` domain and reports its period and high time in `clk_in` cycles.
- For a signal produced by the divider with even `div`, `period_out` = `div` and `high_out` = `div`/2.
- Flags lock after repeated equal periods, and flags a stall when no edge arrives.
- Used on-chip to check generated clocks and to recover the division ratio.

Parameters:
- WIDTH, 8, width of the division factor being measured. Internal count width CW = WIDTH+1, MAX = 2^CW-1.
- SYNC_STAGES, 2, synchroniser flops on `sig_in` (minimum 2).
- LOCK_COUNT, 4, consecutive equal periods required to assert `locked` (minimum 2).

Ports:
- clk_in      input   1      measurement clock
- rst         input   1      synchronous, active-high reset
- sig_in      input   1      signal under measurement, asynchronous to `clk_in`
- period_out  output  CW     last measured period, in `clk_in` cycles
- high_out    output  CW     last measured high time, in `clk_in` cycles
- meas_valid  output  1      one-cycle pulse when `period_out`/`high_out` update
- locked      output  1      LOCK_COUNT consecutive identical periods seen
- stalled     output  1      no edge within MAX cycles; sticky until next `meas_valid`

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk_in. While rst is high:
  - all synchroniser flops = 0, state = IDLE, all counters = 0;
  - `period_out` = 0, `high_out` = 0, `meas_valid` = 0, `locked` = 0, `stalled` = 0.
- Synchronisation and edge detect:
  - `sig_s` = `sig_in` after SYNC_STAGES flops; `sig_d` = `sig_s` delayed by 1 cycle.
  - `rise` = `sig_s` & ~`sig_d`; `fall` = ~`sig_s` & `sig_d`.
- Counters: `per_cnt` (CW bits) counts cycles since the last rise; `hi_cap` (CW) holds the high time; `match_cnt` counts equal periods; `prev_per` (CW) holds the previous period.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on `rise` → HIGH, `per_cnt` <= 1. Otherwise hold.
  - HIGH: `per_cnt` <= `per_cnt`+1 each cycle. On `fall` → LOW and `hi_cap` <= `per_cnt`.
  - LOW: `per_cnt` <= `per_cnt`+1. On `rise`:
    - `period_out` <= `per_cnt`, `high_out` <= `hi_cap`, `meas_valid` <= 1 for one cycle, `stalled` <= 0;
    - `per_cnt` <= 1, → HIGH (back-to-back measurement, no gap).
  - Timeout: in HIGH or LOW, if `per_cnt` == MAX and the pending edge for that state is absent:
    - → IDLE, `stalled` <= 1, `locked` <= 0, `match_cnt` <= 0;
    - `period_out`/`high_out` hold their last values. Never wrap.
- Lock logic, evaluated on each measurement:
  - if `match_cnt` == 0 or new period ≠ `prev_per`: `match_cnt` <= 1, `locked` <= 0;
  - else `match_cnt` <= min(`match_cnt`+1, LOCK_COUNT); `locked` <= 1 when the new `match_cnt` == LOCK_COUNT;
  - `prev_per` <= new period.
- Latency:
  - `sig_in` rising at the input → `meas_valid` high SYNC_STAGES+1 `clk_in` cycles later.
  - Outputs are registered and valid in the same cycle as `meas_valid`.
- Boundary conditions:
  - A glitch shorter than one `clk_in` period may be missed; that is not an error.
  - Minimum measurable high and low time after sync is 1 cycle each, giving period 2.
  - `sig_s` high when reset releases produces a `rise` after sync; measurement starts there.
  - The partial period before the first `rise` is never reported.
  - Reset mid-measurement discards all state; the next report needs a fresh rise→fall→rise.
  - `rise` and timeout in the same cycle (LOW, `per_cnt` == MAX): the `rise` wins and the period MAX is reported.

Test Plan:
- Divider model, `div`=10 (high 5 / low 5), WIDTH=8 → `meas_valid` every 10 cycles with `period_out`=10 and `high_out`=5; `locked`=1 on the 4th valid.
- Asymmetric `sig_in`, high 3 / low 7 → `period_out`=10, `high_out`=3; minimum case high 1 / low 1 → `period_out`=2, `high_out`=1.
- Running at `div`=4 and locked, switch to `div`=6:
  - `locked` drops on the first period ≠ 4, including any mixed transition period;
  - `locked` reasserts after 4 consecutive `period_out`=6.
- Hold `sig_in`=1 for 600 cycles after a rise:
  - `stalled`=1 once `per_cnt` reaches 511, `locked`=0, outputs hold, state IDLE;
  - resuming `div`=8 clears `stalled` on the first `meas_valid` with `period_out`=8.
- Assert rst during HIGH with `div`=12 running:
  - all outputs 0 during reset;
  - after release, the first `meas_valid` shows `period_out`=12, never a truncated value.
- Latency check: with SYNC_STAGES=2, `meas_valid` rises exactly 3 `clk_in` cycles after the `sig_in` rising edge that closes a period.
